// File: rtl/zigbee_pkg.sv
// Shared types and the 802.15.4 2.4 GHz symbol-to-chip table.
// Chip words are stored with bit i holding chip ci, so c0 sits in the LSB.
package zigbee_pkg;

  localparam int SYMBOL_W         = 4;
  localparam int CHIPS_PER_SYMBOL = 32;

  typedef logic [CHIPS_PER_SYMBOL-1:0] chip_word_t;

  typedef enum logic {
    IDLE,
    SPREAD
  } spread_state_t;

  // c0..c31 = 1101 1001 1100 0011 0101 0010 0010 1110
  localparam chip_word_t BASE_CHIPS    = 32'h744A_C39B;
  localparam chip_word_t ODD_CHIP_MASK = 32'hAAAA_AAAA;

  // Symbols 1-7 delay the base sequence by 4*s chips, which is a left rotate
  // of the LSB-first word. Symbols 8-15 invert the odd chips of symbol s-8.
  function automatic chip_word_t make_chips(input int sym);
    logic [2*CHIPS_PER_SYMBOL-1:0] dbl;
    chip_word_t                    word;
    dbl  = {BASE_CHIPS, BASE_CHIPS} >> (CHIPS_PER_SYMBOL - 4 * (sym % 8));
    word = dbl[CHIPS_PER_SYMBOL-1:0];
    if (sym >= 8) begin
      word = word ^ ODD_CHIP_MASK;
    end
    return word;
  endfunction

  localparam chip_word_t CHIP_TABLE [16] = '{
    make_chips(0),  make_chips(1),  make_chips(2),  make_chips(3),
    make_chips(4),  make_chips(5),  make_chips(6),  make_chips(7),
    make_chips(8),  make_chips(9),  make_chips(10), make_chips(11),
    make_chips(12), make_chips(13), make_chips(14), make_chips(15)
  };

endpackage

// File: rtl/zigbee_chip_rom.sv
// Combinational symbol -> 32-chip PN word lookup.
module zigbee_chip_rom
  import zigbee_pkg::*;
(
  input  logic [SYMBOL_W-1:0] symbol,
  output chip_word_t          chips
);

  assign chips = CHIP_TABLE[symbol];

endmodule

// File: rtl/zigbee_chip_spreader.sv
// Pops 4-bit symbols and streams their 32 PN chips serially, each chip held
// CLK_PER_CHIP cycles, with I/Q tagging, strobes and underrun indication.
module zigbee_chip_spreader
  import zigbee_pkg::*;
#(
  parameter int CLK_PER_CHIP = 4
) (
  input  logic                inClock,
  input  logic                inReset,
  input  logic                inTxEnable,
  input  logic [SYMBOL_W-1:0] inSymbol,
  input  logic                inSymbolValid,
  output logic                outSymbolReady,
  output logic                outChip,
  output logic                outChipIsQ,
  output logic                outChipStrobe,
  output logic                outLastChip,
  output logic                outBusy,
  output logic                outUnderrun
);

  localparam int              PRESC_W    = (CLK_PER_CHIP > 1) ? $clog2(CLK_PER_CHIP) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_PER_CHIP - 1);
  localparam logic [4:0]      LAST_CHIP  = 5'(CHIPS_PER_SYMBOL - 1);

  spread_state_t      state_reg, state_next;
  chip_word_t         word_reg, word_next;
  logic [4:0]         idx_reg, idx_next;
  logic [PRESC_W-1:0] presc_reg, presc_next;
  logic chip_reg, chip_next;
  logic is_q_reg, is_q_next;
  logic strobe_reg, strobe_next;
  logic last_reg, last_next;
  logic busy_reg, busy_next;
  logic underrun_reg, underrun_next;

  chip_word_t rom_chips;
  logic       end_of_symbol;
  logic       accept;

  zigbee_chip_rom u_rom (
    .symbol (inSymbol),
    .chips  (rom_chips)
  );

  assign end_of_symbol  = (state_reg == SPREAD) && (idx_reg == LAST_CHIP) &&
                          (presc_reg == PRESC_LAST);
  assign outSymbolReady = inTxEnable && ((state_reg == IDLE) || end_of_symbol);
  assign accept         = outSymbolReady && inSymbolValid;

  // Outputs are derived from the next chip position so they are registered
  // and line up with the state they describe.
  always_comb begin
    state_next    = state_reg;
    word_next     = word_reg;
    idx_next      = idx_reg;
    presc_next    = presc_reg;
    underrun_next = 1'b0;
    if (accept) begin
      state_next = SPREAD;
      word_next  = rom_chips;
      idx_next   = '0;
      presc_next = '0;
    end else if (state_reg == SPREAD) begin
      if (end_of_symbol) begin
        state_next    = IDLE;
        idx_next      = '0;
        presc_next    = '0;
        underrun_next = inTxEnable;
      end else if (presc_reg == PRESC_LAST) begin
        presc_next = '0;
        idx_next   = idx_reg + 5'd1;
      end else begin
        presc_next = presc_reg + PRESC_W'(1);
      end
    end
    busy_next   = (state_next == SPREAD);
    chip_next   = busy_next && word_next[idx_next];
    is_q_next   = busy_next && idx_next[0];
    strobe_next = busy_next && (presc_next == '0);
    last_next   = busy_next && (idx_next == LAST_CHIP);
  end

  always_ff @(posedge inClock or posedge inReset) begin
    if (inReset) begin
      state_reg    <= IDLE;
      word_reg     <= '0;
      idx_reg      <= '0;
      presc_reg    <= '0;
      chip_reg     <= 1'b0;
      is_q_reg     <= 1'b0;
      strobe_reg   <= 1'b0;
      last_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      word_reg     <= word_next;
      idx_reg      <= idx_next;
      presc_reg    <= presc_next;
      chip_reg     <= chip_next;
      is_q_reg     <= is_q_next;
      strobe_reg   <= strobe_next;
      last_reg     <= last_next;
      busy_reg     <= busy_next;
      underrun_reg <= underrun_next;
    end
  end

  assign outChip       = chip_reg;
  assign outChipIsQ    = is_q_reg;
  assign outChipStrobe = strobe_reg;
  assign outLastChip   = last_reg;
  assign outBusy       = busy_reg;
  assign outUnderrun   = underrun_reg;

endmodule
